proc_sequencer: RTL and testbench
=================================

PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 SHALL have these ports: clk_pi in 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have reset_pi in 1: synchronous, active-high reset.
REQ-003 SHALL have instr_cls_pi in 17: decoded class flags, one-hot or all-zero; bit order arith_2op, arith_1op, movi_lo, movi_hi, addi, subi, load, store, beq, bge, ble, bc, jump, stc, stb, halt, rst (bit 0..16).
REQ-004 SHALL have cond_pi in 4: {carry, le, ge, eq} comparison results for the current source registers.
REQ-005 SHALL have mem_ack_pi in 1: memory completes the pending request this cycle.
REQ-006 SHALL have mem_req_po out 1: memory request, held until acknowledged.
REQ-007 SHALL have mem_we_po out 1: request is a write (store).
REQ-008 SHALL have mem_addr_sel_po out 1: 0 = PC address, 1 = data address.
REQ-009 SHALL have ir_we_po out 1: load the instruction register.
REQ-010 SHALL have pc_we_po out 1: update the PC.
REQ-011 SHALL have pc_sel_po out 2: PC source, 0 = PC+1, 1 = branch target, 2 = jump target, 3 = zero.
REQ-012 SHALL have rf_we_po out 1: register-file write enable.
REQ-013 SHALL have flag_we_po out 1: update ALU flags.
REQ-014 SHALL have carry_set_po out 1: set the carry flag (one-cycle pulse).
REQ-015 SHALL have borrow_set_po out 1: set the borrow flag (one-cycle pulse).
REQ-016 SHALL have soft_rst_po out 1: one-cycle pulse clearing the register file and flags.
REQ-017 SHALL have halted_po out 1: the core is stopped.
REQ-018 SHALL have instret_po out 16: count of retired instructions.

Function
REQ-019 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEM, HALTED; all outputs except instret_po are decoded from the state and the inputs.
REQ-020 IDLE: all strobes 0; always moves to FETCH on the next cycle.
REQ-021 FETCH: mem_req_po=1 and mem_addr_sel_po=0; the state holds while mem_ack_pi=0.
REQ-022 FETCH on the mem_ack_pi cycle: ir_we_po=1, then move to DECODE; an ack in the same cycle as the request is legal.
REQ-023 DECODE: lasts exactly one cycle with all strobes 0, then moves to EXECUTE.
REQ-024 EXECUTE, ALU classes (arith_2op, arith_1op, movi_lo, movi_hi, addi, subi): rf_we_po=1; flag_we_po=1 except for movi; pc_we_po=1 with pc_sel_po=0; then FETCH.
REQ-025 EXECUTE, branch classes: pc_we_po=1; pc_sel_po=1 when the matching cond_pi bit is 1, else pc_sel_po=0; then FETCH.
REQ-026 EXECUTE, jump: pc_we_po=1, pc_sel_po=2; then FETCH.
REQ-027 EXECUTE, stc or stb: pulse carry_set_po or borrow_set_po respectively; pc_we_po=1, pc_sel_po=0; then FETCH.
REQ-028 EXECUTE, rst: soft_rst_po=1, pc_we_po=1, pc_sel_po=3; clear instret_po; then FETCH.
REQ-029 EXECUTE, halt: no PC update; move to HALTED, which is left only by reset_pi.
REQ-030 EXECUTE, all-zero class (NOP or an undefined control word): pc_we_po=1 with pc_sel_po=0; then FETCH.
REQ-031 EXECUTE, load or store: no strobes; move to MEM.
REQ-032 MEM: mem_req_po=1, mem_addr_sel_po=1, mem_we_po=store; the state holds while mem_ack_pi=0.
REQ-033 MEM on the mem_ack_pi cycle: rf_we_po=1 for load; pc_we_po=1 with pc_sel_po=0; then FETCH.
REQ-034 Once asserted, mem_req_po, mem_we_po and mem_addr_sel_po SHALL stay stable until the ack cycle.
REQ-035 mem_ack_pi SHALL be ignored outside FETCH and MEM.
REQ-036 When more than one class bit is set, priority SHALL be halt > rst > jump > branch > load/store > ALU > stc/stb, acting on the highest bit only.
REQ-037 instret_po SHALL increment by 1 on each pc_we_po cycle except rst, and wrap from 0xFFFF to 0x0000.
REQ-038 Latency with zero-wait ack: non-memory instruction 3 cycles; load/store 4 cycles.
REQ-039 halted_po SHALL be 1 exactly while in HALTED.

Reset
REQ-040 reset_pi=1 SHALL move the state to IDLE and clear instret_po at the next edge, from any state, including mid-FETCH or mid-MEM with an ack pending.
REQ-041 While reset_pi=1, and in the cycle after it is released, every output SHALL be 0.
REQ-042 An outstanding memory request SHALL be abandoned on reset; a late ack SHALL be ignored.

Structure
REQ-043 Package proc_ctrl_pkg SHALL hold the state encoding, the pc_sel codes, and the instr_cls_pi bit indices.
REQ-044 Branch-condition selection SHALL be a combinational sub-module, branch_resolve (class bits plus cond_pi in, taken out).

Verification
REQ-045 Reset then addi, ack always 1 -> IDLE, FETCH(ir_we), DECODE, EXECUTE(rf_we, flag_we, pc_we, sel 0); instret=1.
REQ-046 FETCH with ack delayed 3 cycles -> mem_req held 4 cycles, ir_we only on the ack cycle.
REQ-047 beq with cond_pi=0001 -> pc_sel=1; with cond_pi=0000 -> pc_sel=0; both pc_we=1.
REQ-048 store with ack after 2 cycles in MEM -> mem_we=1, addr_sel=1 held; no rf_we; pc_we on the ack cycle.
REQ-049 halt -> halted_po=1 for 20 cycles with no pc_we; reset_pi -> IDLE, all outputs 0.
REQ-050 Reset asserted mid-MEM, then a late ack -> state IDLE then FETCH; the ack is ignored; instret=0.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// rtl/proc_ctrl_pkg.sv - shared encodings for the processor control sequencer
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_HALTED  = 3'd5
  } state_t;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_ZERO   = 2'd3;

  localparam int CLS_W         = 17;
  localparam int CLS_ARITH_2OP = 0;
  localparam int CLS_ARITH_1OP = 1;
  localparam int CLS_MOVI_LO   = 2;
  localparam int CLS_MOVI_HI   = 3;
  localparam int CLS_ADDI      = 4;
  localparam int CLS_SUBI      = 5;
  localparam int CLS_LOAD      = 6;
  localparam int CLS_STORE     = 7;
  localparam int CLS_BEQ       = 8;
  localparam int CLS_BGE       = 9;
  localparam int CLS_BLE       = 10;
  localparam int CLS_BC        = 11;
  localparam int CLS_JUMP      = 12;
  localparam int CLS_STC       = 13;
  localparam int CLS_STB       = 14;
  localparam int CLS_HALT      = 15;
  localparam int CLS_RST       = 16;

endpackage

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - picks the comparison bit matching the active branch class
module branch_resolve
  import proc_ctrl_pkg::*;
(
  input  logic [CLS_W-1:0] instr_cls,
  input  logic [3:0]       cond,
  output logic             is_branch,
  output logic             taken
);

  // cond is {carry, le, ge, eq}; the highest set branch bit decides
  always_comb begin
    taken     = 1'b0;
    is_branch = instr_cls[CLS_BC] | instr_cls[CLS_BLE] |
                instr_cls[CLS_BGE] | instr_cls[CLS_BEQ];
    if (instr_cls[CLS_BC])       taken = cond[3];
    else if (instr_cls[CLS_BLE]) taken = cond[2];
    else if (instr_cls[CLS_BGE]) taken = cond[1];
    else if (instr_cls[CLS_BEQ]) taken = cond[0];
  end

endmodule

// File: rtl/proc_sequencer.sv
// rtl/proc_sequencer.sv - fetch/decode/execute/memory control sequencer
module proc_sequencer
  import proc_ctrl_pkg::*;
(
  input  logic             clk_pi,
  input  logic             reset_pi,
  input  logic [CLS_W-1:0] instr_cls_pi,
  input  logic [3:0]       cond_pi,
  input  logic             mem_ack_pi,
  output logic             mem_req_po,
  output logic             mem_we_po,
  output logic             mem_addr_sel_po,
  output logic             ir_we_po,
  output logic             pc_we_po,
  output logic [1:0]       pc_sel_po,
  output logic             rf_we_po,
  output logic             flag_we_po,
  output logic             carry_set_po,
  output logic             borrow_set_po,
  output logic             soft_rst_po,
  output logic             halted_po,
  output logic [15:0]      instret_po
);

  state_t      state_q, state_d;
  logic        mem_store_q, mem_store_d;
  logic [15:0] instret_q;
  logic        is_branch, br_taken;

  branch_resolve u_branch_resolve (
    .instr_cls (instr_cls_pi),
    .cond      (cond_pi),
    .is_branch (is_branch),
    .taken     (br_taken)
  );

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q     <= ST_IDLE;
      mem_store_q <= 1'b0;
      instret_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      mem_store_q <= mem_store_d;
      if (pc_we_po && soft_rst_po) instret_q <= 16'd0;
      else if (pc_we_po)           instret_q <= instret_q + 16'd1;
    end
  end

  always_comb begin
    state_d         = state_q;
    mem_store_d     = mem_store_q;
    mem_req_po      = 1'b0;
    mem_we_po       = 1'b0;
    mem_addr_sel_po = 1'b0;
    ir_we_po        = 1'b0;
    pc_we_po        = 1'b0;
    pc_sel_po       = PC_INC;
    rf_we_po        = 1'b0;
    flag_we_po      = 1'b0;
    carry_set_po    = 1'b0;
    borrow_set_po   = 1'b0;
    soft_rst_po     = 1'b0;
    halted_po       = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req_po = 1'b1;
        if (mem_ack_pi) begin
          ir_we_po = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        if (instr_cls_pi[CLS_HALT]) begin
          state_d = ST_HALTED;
        end else if (instr_cls_pi[CLS_RST]) begin
          soft_rst_po = 1'b1;
          pc_we_po    = 1'b1;
          pc_sel_po   = PC_ZERO;
        end else if (instr_cls_pi[CLS_JUMP]) begin
          pc_we_po  = 1'b1;
          pc_sel_po = PC_JUMP;
        end else if (is_branch) begin
          pc_we_po  = 1'b1;
          pc_sel_po = br_taken ? PC_BRANCH : PC_INC;
        end else if (instr_cls_pi[CLS_STORE] || instr_cls_pi[CLS_LOAD]) begin
          // latch the direction so the memory request stays stable until ack
          mem_store_d = instr_cls_pi[CLS_STORE];
          state_d     = ST_MEM;
        end else if (|instr_cls_pi[CLS_SUBI:CLS_ARITH_2OP]) begin
          rf_we_po   = 1'b1;
          pc_we_po   = 1'b1;
          // addi/subi outrank movi; arith ops only win when no movi bit is set
          flag_we_po = instr_cls_pi[CLS_SUBI] | instr_cls_pi[CLS_ADDI] |
                       ~(instr_cls_pi[CLS_MOVI_HI] | instr_cls_pi[CLS_MOVI_LO]);
        end else if (instr_cls_pi[CLS_STB]) begin
          borrow_set_po = 1'b1;
          pc_we_po      = 1'b1;
        end else if (instr_cls_pi[CLS_STC]) begin
          carry_set_po = 1'b1;
          pc_we_po     = 1'b1;
        end else begin
          pc_we_po = 1'b1;
        end
      end
      ST_MEM: begin
        mem_req_po      = 1'b1;
        mem_addr_sel_po = 1'b1;
        mem_we_po       = mem_store_q;
        if (mem_ack_pi) begin
          rf_we_po = ~mem_store_q;
          pc_we_po = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_HALTED: halted_po = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    // outputs are forced quiet while reset is held, whatever the state
    if (reset_pi) begin
      mem_req_po      = 1'b0;
      mem_we_po       = 1'b0;
      mem_addr_sel_po = 1'b0;
      ir_we_po        = 1'b0;
      pc_we_po        = 1'b0;
      pc_sel_po       = PC_INC;
      rf_we_po        = 1'b0;
      flag_we_po      = 1'b0;
      carry_set_po    = 1'b0;
      borrow_set_po   = 1'b0;
      soft_rst_po     = 1'b0;
      halted_po       = 1'b0;
    end
  end

  assign instret_po = reset_pi ? 16'd0 : instret_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// tb/tb_proc_sequencer.sv - scoreboard bench for proc_sequencer
module tb_proc_sequencer;

  localparam int B_ARITH_2OP = 0, B_MOVI_LO = 2, B_MOVI_HI = 3, B_ADDI = 4;
  localparam int B_LOAD = 6, B_STORE = 7, B_BEQ = 8, B_BGE = 9, B_BLE = 10, B_BC = 11;
  localparam int B_JUMP = 12, B_STC = 13, B_STB = 14, B_HALT = 15, B_RST = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [16:0] cls = '0;
  logic [3:0]  cond = '0;
  logic        ack = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, flag_we;
  logic        carry_set, borrow_set, soft_rst, halted;
  logic [1:0]  pc_sel;
  logic [15:0] instret;

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;
  logic [15:0] exp_ir = '0;
  logic [28:0] exp_q[$];

  always #5 clk = ~clk;

  proc_sequencer dut (
    .clk_pi(clk), .reset_pi(reset), .instr_cls_pi(cls), .cond_pi(cond),
    .mem_ack_pi(ack), .mem_req_po(mem_req), .mem_we_po(mem_we),
    .mem_addr_sel_po(mem_addr_sel), .ir_we_po(ir_we), .pc_we_po(pc_we),
    .pc_sel_po(pc_sel), .rf_we_po(rf_we), .flag_we_po(flag_we),
    .carry_set_po(carry_set), .borrow_set_po(borrow_set),
    .soft_rst_po(soft_rst), .halted_po(halted), .instret_po(instret)
  );

  function automatic logic [16:0] c1(input int b);
    c1 = 17'd1 << b;
  endfunction

  // strobe vector: req we asel irwe pcwe sel[1:0] rfwe fwe cs bs sr hl
  function automatic logic [12:0] sv(input bit req, we, asel, irwe, pcwe,
                                     input logic [1:0] sel,
                                     input bit rfwe, fwe, cs, bs, sr, hl);
    sv = {req, we, asel, irwe, pcwe, sel, rfwe, fwe, cs, bs, sr, hl};
  endfunction

  task automatic check_eq(input string tag, input logic [28:0] obs, input logic [28:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d strobes got=%013b want=%013b instret got=%0d want=%0d",
               tag, cycle_no, obs[28:16], exp[28:16], obs[15:0], exp[15:0]);
    end
  endtask

  task automatic cyc(input string tag, input bit r, input logic [16:0] c,
                     input logic [3:0] cd, input bit a, input logic [12:0] s);
    logic [28:0] got;
    @(negedge clk);
    reset = r; cls = c; cond = cd; ack = a;
    exp_q.push_back({s, exp_ir});
    #2;
    got = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, flag_we,
           carry_set, borrow_set, soft_rst, halted, instret};
    check_eq(tag, got, exp_q.pop_front());
    cycle_no++;
  endtask

  // mem: 0 none, 1 load, 2 store
  task automatic instr(input string tag, input logic [16:0] c, input logic [3:0] cd,
                       input int fwait, input int mwait, input int mem,
                       input logic [12:0] exec_s);
    for (int i = 0; i < fwait; i++) cyc({tag, ":fetch_wait"}, 0, c, cd, 0, sv(1,0,0,0,0,0,0,0,0,0,0,0));
    cyc({tag, ":fetch"}, 0, c, cd, 1, sv(1,0,0,1,0,0,0,0,0,0,0,0));
    cyc({tag, ":decode"}, 0, c, cd, 1, 13'd0);
    cyc({tag, ":exec"}, 0, c, cd, 1, exec_s);
    if (exec_s[8]) exp_ir = exec_s[1] ? 16'd0 : exp_ir + 16'd1;
    if (mem != 0) begin
      for (int i = 0; i < mwait; i++)
        cyc({tag, ":mem_wait"}, 0, c, cd, 0, sv(1, mem == 2, 1,0,0,0,0,0,0,0,0,0));
      cyc({tag, ":mem_ack"}, 0, c, cd, 1, sv(1, mem == 2, 1, 0, 1, 0, mem == 1, 0,0,0,0,0));
      exp_ir = exp_ir + 16'd1;
    end
  endtask

  initial begin
    cyc("reset", 1, 0, 0, 1, 13'd0);
    cyc("reset", 1, 0, 0, 1, 13'd0);
    cyc("idle", 0, c1(B_ADDI), 0, 1, 13'd0);
    instr("addi", c1(B_ADDI), 0, 0, 0, 0, sv(0,0,0,0,1,0,1,1,0,0,0,0));
    instr("beq_t", c1(B_BEQ), 4'b0001, 3, 0, 0, sv(0,0,0,0,1,1,0,0,0,0,0,0));
    instr("beq_nt", c1(B_BEQ), 4'b0000, 0, 0, 0, sv(0,0,0,0,1,0,0,0,0,0,0,0));
    instr("bge_t", c1(B_BGE), 4'b0010, 0, 0, 0, sv(0,0,0,0,1,1,0,0,0,0,0,0));
    instr("ble_t", c1(B_BLE), 4'b0100, 0, 0, 0, sv(0,0,0,0,1,1,0,0,0,0,0,0));
    instr("bc_t", c1(B_BC), 4'b1000, 0, 0, 0, sv(0,0,0,0,1,1,0,0,0,0,0,0));
    instr("bc_nt", c1(B_BC), 4'b0111, 0, 0, 0, sv(0,0,0,0,1,0,0,0,0,0,0,0));
    instr("store", c1(B_STORE), 0, 0, 2, 2, 13'd0);
    instr("load", c1(B_LOAD), 0, 1, 0, 1, 13'd0);
    instr("jump", c1(B_JUMP), 0, 0, 0, 0, sv(0,0,0,0,1,2,0,0,0,0,0,0));
    instr("stc", c1(B_STC), 0, 0, 0, 0, sv(0,0,0,0,1,0,0,0,1,0,0,0));
    instr("stb", c1(B_STB), 0, 0, 0, 0, sv(0,0,0,0,1,0,0,0,0,1,0,0));
    instr("prio_jump", c1(B_JUMP) | c1(B_ADDI) | c1(B_STC), 0, 0, 0, 0, sv(0,0,0,0,1,2,0,0,0,0,0,0));
    instr("movi_lo", c1(B_MOVI_LO), 0, 0, 0, 0, sv(0,0,0,0,1,0,1,0,0,0,0,0));
    instr("arith2", c1(B_ARITH_2OP), 0, 0, 0, 0, sv(0,0,0,0,1,0,1,1,0,0,0,0));
    instr("prio_addi", c1(B_MOVI_HI) | c1(B_ADDI), 0, 0, 0, 0, sv(0,0,0,0,1,0,1,1,0,0,0,0));
    instr("prio_store", c1(B_STORE) | c1(B_ADDI), 0, 0, 0, 2, 13'd0);
    instr("prio_branch", c1(B_BEQ) | c1(B_LOAD), 4'b0001, 0, 0, 0, sv(0,0,0,0,1,1,0,0,0,0,0,0));
    instr("nop", 17'd0, 0, 0, 0, 0, sv(0,0,0,0,1,0,0,0,0,0,0,0));
    instr("rst", c1(B_RST) | c1(B_JUMP), 0, 0, 0, 0, sv(0,0,0,0,1,3,0,0,0,0,1,0));
    instr("addi2", c1(B_ADDI), 0, 0, 0, 0, sv(0,0,0,0,1,0,1,1,0,0,0,0));
    instr("halt", c1(B_HALT) | c1(B_RST), 0, 0, 0, 0, 13'd0);
    for (int i = 0; i < 20; i++) cyc("halted", 0, c1(B_ADDI), 0, 1, sv(0,0,0,0,0,0,0,0,0,0,0,1));
    exp_ir = '0;
    cyc("halt_reset", 1, c1(B_ADDI), 0, 1, 13'd0);
    cyc("halt_idle", 0, c1(B_LOAD), 0, 1, 13'd0);
    cyc("mid_fetch", 0, c1(B_LOAD), 0, 1, sv(1,0,0,1,0,0,0,0,0,0,0,0));
    cyc("mid_decode", 0, c1(B_LOAD), 0, 1, 13'd0);
    cyc("mid_exec", 0, c1(B_LOAD), 0, 1, 13'd0);
    cyc("mid_mem", 0, c1(B_LOAD), 0, 0, sv(1,0,1,0,0,0,0,0,0,0,0,0));
    cyc("mid_reset", 1, c1(B_LOAD), 0, 0, 13'd0);
    cyc("late_ack", 0, c1(B_ADDI), 0, 1, 13'd0);
    cyc("post_fetch", 0, c1(B_ADDI), 0, 0, sv(1,0,0,0,0,0,0,0,0,0,0,0));
    instr("post_addi", c1(B_ADDI), 0, 0, 0, 0, sv(0,0,0,0,1,0,1,1,0,0,0,0));
    cyc("post_instret", 0, c1(B_ADDI), 0, 0, sv(1,0,0,0,0,0,0,0,0,0,0,0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
